// File: rtl/sd_dat_pkg.sv
// sd_dat_pkg: shared state encoding, CRC-status tokens and default widths for the SD DAT controller
package sd_dat_pkg;
   localparam int BLK_CNT_W_DEF = 8;
   localparam int TIMEOUT_W_DEF = 16;
   localparam int DATA_W_DEF    = 32;
   localparam logic [2:0] CRC_OK  = 3'b010;
   localparam logic [2:0] CRC_ERR = 3'b101;
   typedef enum logic [3:0] {
      S_RESET              = 4'd0,
      S_IDLE               = 4'd1,
      S_LOAD_WRITE         = 4'd2,
      S_SEND               = 4'd3,
      S_WAIT_CRC           = 4'd4,
      S_WAIT_BUSY          = 4'd5,
      S_READ               = 4'd6,
      S_READ_FIFO_WRITE    = 4'd7,
      S_READ_WRAPPER_RESET = 4'd8,
      S_WAIT_ACK           = 4'd9
   } state_e;
endpackage

// File: rtl/sd_dat_phys_ctrl_if.sv
// sd_dat_phys_ctrl_if: host, serial-wrapper, pad and FIFO signals of the SD DAT controller
interface sd_dat_phys_ctrl_if
   import sd_dat_pkg::*;
   #(parameter int BLK_CNT_W = BLK_CNT_W_DEF,
     parameter int TIMEOUT_W = TIMEOUT_W_DEF,
     parameter int DATA_W    = DATA_W_DEF);
   logic                 strobe_in, ack_in, idle_in, write_read, multiple;
   logic [BLK_CNT_W-1:0] blocks, blocks_done;
   logic [TIMEOUT_W-1:0] timeout_reg;
   logic                 serial_ready, complete, ack_out, data_timeout, crc_error;
   logic                 transmission_complete, reception_complete, dat0_in;
   logic [2:0]           crc_status;
   logic [DATA_W-1:0]    data_read, data_read_to_fifo;
   logic                 reset_wrapper, load_send, enable_pts_wrapper, enable_stp_wrapper, waiting_response;
   logic                 pad_state, pad_enable, write_fifo_enable, read_fifo_enable;
   modport master (
      output strobe_in, ack_in, idle_in, write_read, multiple, blocks, timeout_reg,
             transmission_complete, reception_complete, crc_status, data_read, dat0_in,
      input  serial_ready, complete, ack_out, data_timeout, crc_error, blocks_done,
             reset_wrapper, load_send, enable_pts_wrapper, enable_stp_wrapper, waiting_response,
             pad_state, pad_enable, write_fifo_enable, read_fifo_enable, data_read_to_fifo
   );
   modport slave (
      input  strobe_in, ack_in, idle_in, write_read, multiple, blocks, timeout_reg,
             transmission_complete, reception_complete, crc_status, data_read, dat0_in,
      output serial_ready, complete, ack_out, data_timeout, crc_error, blocks_done,
             reset_wrapper, load_send, enable_pts_wrapper, enable_stp_wrapper, waiting_response,
             pad_state, pad_enable, write_fifo_enable, read_fifo_enable, data_read_to_fifo
   );
endinterface

// File: rtl/sd_dat_timeout.sv
// sd_dat_timeout: clearable, saturating cycle counter; hit flags the cycle the count reaches limit_i
module sd_dat_timeout #(
   parameter int TIMEOUT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr_i,
   input  logic                 en_i,
   input  logic [TIMEOUT_W-1:0] limit_i,
   output logic                 hit_o
);
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   assign cnt_d = clr_i ? '0 : (en_i && cnt_q < limit_i) ? cnt_q + TIMEOUT_W'(1) : cnt_q;
   // limit 0 disables; otherwise hit in the cycle whose increment reaches the limit
   assign hit_o = en_i && (limit_i != '0) && (cnt_q >= limit_i - TIMEOUT_W'(1));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/sd_dat_phys_ctrl.sv
// sd_dat_phys_ctrl: SD DAT-line block read/write sequencer with CRC-status check and per-block timeout
// SD_DAT_BUSY_WAIT_EN: when defined, writes wait for DAT0 to leave busy after each accepted block
module sd_dat_phys_ctrl
   import sd_dat_pkg::*;
   #(parameter int BLK_CNT_W = BLK_CNT_W_DEF,
     parameter int TIMEOUT_W = TIMEOUT_W_DEF,
     parameter int DATA_W    = DATA_W_DEF)
   (
   input logic               sd_clock,
   input logic               reset,
   sd_dat_phys_ctrl_if.slave bus
);
   state_e               state_q, state_d;
   logic [BLK_CNT_W-1:0] blocks_done_q, blocks_done_d, done_inc;
   logic                 timeout_q, timeout_d, crc_err_q, crc_err_d;
   logic [BLK_CNT_W:0]   done_p1, target;
   logic                 last, to_hit, timed, to_clr;
   assign done_p1  = {1'b0, blocks_done_q} + (BLK_CNT_W+1)'(1);
   assign target   = (bus.blocks == '0) ? (BLK_CNT_W+1)'(1) : {1'b0, bus.blocks};
   assign last     = !bus.multiple || done_p1 == target;
   assign done_inc = &blocks_done_q ? blocks_done_q : done_p1[BLK_CNT_W-1:0];
   assign timed    = state_q inside {S_WAIT_CRC, S_WAIT_BUSY, S_READ};
   assign to_clr   = !(state_d inside {S_WAIT_CRC, S_WAIT_BUSY, S_READ}) || state_d != state_q;
`ifdef SD_DAT_BUSY_WAIT_EN
   logic last_busy;
   // in WAIT_BUSY the accepted block has already been counted
   assign last_busy = !bus.multiple || {1'b0, blocks_done_q} == target;
`endif
   sd_dat_timeout #(.TIMEOUT_W(TIMEOUT_W)) u_timeout (
      .clk(sd_clock), .rst_n(reset), .clr_i(to_clr), .en_i(timed),
      .limit_i(bus.timeout_reg), .hit_o(to_hit)
   );
   always_comb begin
      state_d       = state_q;
      blocks_done_d = blocks_done_q;
      timeout_d     = timeout_q;
      crc_err_d     = crc_err_q;
      if (bus.idle_in) state_d = S_IDLE;
      else
         case (state_q)
            S_RESET: state_d = S_IDLE;
            S_IDLE:
               if (bus.strobe_in) begin
                  blocks_done_d = '0;
                  timeout_d     = 1'b0;
                  crc_err_d     = 1'b0;
                  state_d       = bus.write_read ? S_LOAD_WRITE : S_READ;
               end
            S_LOAD_WRITE: state_d = S_SEND;
            S_SEND: state_d = bus.transmission_complete ? S_WAIT_CRC : S_SEND;
            S_WAIT_CRC:
               if (bus.reception_complete) begin
                  if (bus.crc_status == CRC_OK) begin
                     blocks_done_d = done_inc;
`ifdef SD_DAT_BUSY_WAIT_EN
                     state_d = S_WAIT_BUSY;
`else
                     state_d = last ? S_WAIT_ACK : S_LOAD_WRITE;
`endif
                  end else begin
                     crc_err_d = 1'b1;
                     state_d   = S_WAIT_ACK;
                  end
               end else if (to_hit) begin
                  timeout_d = 1'b1;
                  state_d   = S_WAIT_ACK;
               end
`ifdef SD_DAT_BUSY_WAIT_EN
            S_WAIT_BUSY:
               if (bus.dat0_in) state_d = last_busy ? S_WAIT_ACK : S_LOAD_WRITE;
               else if (to_hit) begin
                  timeout_d = 1'b1;
                  state_d   = S_WAIT_ACK;
               end
`endif
            S_READ:
               if (bus.reception_complete) state_d = S_READ_FIFO_WRITE;
               else if (to_hit) begin
                  timeout_d = 1'b1;
                  state_d   = S_WAIT_ACK;
               end
            S_READ_FIFO_WRITE: begin
               blocks_done_d = done_inc;
               state_d       = last ? S_WAIT_ACK : S_READ_WRAPPER_RESET;
            end
            S_READ_WRAPPER_RESET: state_d = S_READ;
            S_WAIT_ACK: state_d = bus.ack_in ? S_IDLE : S_WAIT_ACK;
            default: state_d = S_IDLE;
         endcase
   end
   always_ff @(posedge sd_clock or negedge reset)
      if (!reset) begin
         state_q       <= S_RESET;
         blocks_done_q <= '0;
         timeout_q     <= 1'b0;
         crc_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         blocks_done_q <= blocks_done_d;
         timeout_q     <= timeout_d;
         crc_err_q     <= crc_err_d;
      end
   assign bus.serial_ready       = state_q == S_IDLE;
   assign bus.complete           = state_q == S_WAIT_ACK;
   assign bus.ack_out            = state_q == S_WAIT_ACK && bus.ack_in;
   assign bus.reset_wrapper      = state_q inside {S_RESET, S_READ_WRAPPER_RESET};
   assign bus.load_send          = state_q == S_SEND;
   assign bus.enable_pts_wrapper = state_q inside {S_LOAD_WRITE, S_SEND};
   assign bus.enable_stp_wrapper = state_q == S_READ;
   assign bus.waiting_response   = state_q == S_WAIT_CRC;
   assign bus.pad_state          = state_q inside {S_LOAD_WRITE, S_SEND};
   assign bus.pad_enable         = state_q inside {S_LOAD_WRITE, S_SEND, S_WAIT_CRC, S_WAIT_BUSY, S_READ};
   assign bus.write_fifo_enable  = state_q == S_LOAD_WRITE;
   assign bus.read_fifo_enable   = state_q == S_READ_FIFO_WRITE;
   assign bus.data_read_to_fifo  = state_q == S_READ_FIFO_WRITE ? bus.data_read : '0;
   assign bus.data_timeout       = timeout_q;
   assign bus.crc_error          = crc_err_q;
   assign bus.blocks_done        = blocks_done_q;
endmodule

// File: tb/tb_sd_dat_phys_ctrl.sv
// tb_sd_dat_phys_ctrl: directed self-checking bench for sd_dat_phys_ctrl (either SD_DAT_BUSY_WAIT_EN setting)
module tb_sd_dat_phys_ctrl;
   logic sd_clock = 1'b0;
   logic reset    = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   sd_dat_phys_ctrl_if #(.BLK_CNT_W(8), .TIMEOUT_W(16), .DATA_W(32)) bus ();
   sd_dat_phys_ctrl #(.BLK_CNT_W(8), .TIMEOUT_W(16), .DATA_W(32)) dut (
      .sd_clock(sd_clock), .reset(reset), .bus(bus)
   );
   always #5 sd_clock = ~sd_clock;
   task automatic step();
      @(posedge sd_clock);
      #1;
   endtask
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // drives one write block from LOAD_WRITE through the CRC token; leaves the DUT one edge past the token
   task automatic write_block(input logic [2:0] tok);
      check("wr_load_fifo", bus.write_fifo_enable, 1);
      check("wr_load_pad", bus.pad_state, 1);
      step();
      check("wr_send", bus.load_send, 1);
      step();
      check("wr_send_hold", bus.load_send, 1);
      bus.transmission_complete = 1;
      step();
      bus.transmission_complete = 0;
      check("wr_wait_crc", bus.waiting_response, 1);
      check("wr_wait_crc_pad", bus.pad_state, 0);
      bus.crc_status = tok;
      bus.reception_complete = 1;
      step();
      bus.reception_complete = 0;
   endtask
   task automatic finish_ack();
      bus.ack_in = 1;
      #1;
      check("ack_out_hi", bus.ack_out, 1);
      step();
      bus.ack_in = 0;
      #1;
      check("ack_out_lo", bus.ack_out, 0);
      check("back_idle", bus.serial_ready, 1);
   endtask
   initial begin
      logic [31:0] word;
      {bus.strobe_in, bus.ack_in, bus.idle_in, bus.write_read, bus.multiple} = '0;
      bus.blocks = 8'd1;
      bus.timeout_reg = '0;
      bus.transmission_complete = 0;
      bus.reception_complete = 0;
      bus.crc_status = 3'b000;
      bus.data_read = '0;
      bus.dat0_in = 1;
      step();
      step();
      check("rst_reset_wrapper", bus.reset_wrapper, 1);
      check("rst_ready", bus.serial_ready, 0);
      check("rst_pad_en", bus.pad_enable, 0);
      check("rst_blocks_done", bus.blocks_done, 0);
      check("rst_flags", {bus.data_timeout, bus.crc_error, bus.complete}, 0);
      reset = 1;
      step();
      check("idle_after_release", bus.serial_ready, 1);
      check("idle_no_wrapper_rst", bus.reset_wrapper, 0);
      // single write, accepted token
      bus.write_read = 1;
      bus.strobe_in = 1;
      step();
      bus.strobe_in = 0;
      write_block(3'b010);
`ifdef SD_DAT_BUSY_WAIT_EN
      check("sw_busy_state", {bus.pad_enable, bus.complete}, 2'b10);
      step();
`endif
      check("sw_complete", bus.complete, 1);
      check("sw_blocks_done", bus.blocks_done, 1);
      check("sw_crc_err", bus.crc_error, 0);
      finish_ack();
      // multi-read, 3 blocks
      bus.write_read = 0;
      bus.multiple = 1;
      bus.blocks = 8'd3;
      bus.strobe_in = 1;
      step();
      bus.strobe_in = 0;
      check("mr_read", bus.enable_stp_wrapper, 1);
      check("mr_cleared", bus.blocks_done, 0);
      for (int b = 0; b < 3; b++) begin
         word = 32'hA5C3_0000 + 32'(b);
         bus.data_read = word;
         check("mr_fifo_zero", bus.data_read_to_fifo, 0);
         bus.reception_complete = 1;
         step();
         bus.reception_complete = 0;
         check("mr_rfw_en", bus.read_fifo_enable, 1);
         check("mr_rfw_data", bus.data_read_to_fifo, word);
         check("mr_rfw_cnt", bus.blocks_done, b);
         step();
         if (b < 2) begin
            check("mr_wrapper_reset", bus.reset_wrapper, 1);
            step();
            check("mr_reread", bus.enable_stp_wrapper, 1);
         end
      end
      check("mr_complete", bus.complete, 1);
      check("mr_blocks_done", bus.blocks_done, 3);
      finish_ack();
      // multi-read with blocks = 0 behaves as a single block
      bus.blocks = 8'd0;
      bus.strobe_in = 1;
      step();
      bus.strobe_in = 0;
      bus.reception_complete = 1;
      step();
      bus.reception_complete = 0;
      step();
      check("b0_complete", bus.complete, 1);
      check("b0_blocks_done", bus.blocks_done, 1);
      finish_ack();
      // multi-write, second token rejected
      bus.write_read = 1;
      bus.blocks = 8'd3;
      bus.strobe_in = 1;
      step();
      bus.strobe_in = 0;
      write_block(3'b010);
`ifdef SD_DAT_BUSY_WAIT_EN
      step();
`endif
      check("mw_next_load", bus.write_fifo_enable, 1);
      check("mw_cnt1", bus.blocks_done, 1);
      write_block(3'b101);
      check("mw_complete", bus.complete, 1);
      check("mw_crc_err", bus.crc_error, 1);
      check("mw_blocks_done", bus.blocks_done, 1);
      finish_ack();
      // read timeout after 10 cycles
      bus.write_read = 0;
      bus.multiple = 0;
      bus.timeout_reg = 16'd10;
      bus.strobe_in = 1;
      step();
      bus.strobe_in = 0;
      check("to_crc_cleared", bus.crc_error, 0);
      for (int i = 0; i < 9; i++) step();
      check("to_not_yet", bus.data_timeout, 0);
      check("to_still_read", bus.enable_stp_wrapper, 1);
      step();
      check("to_flag", bus.data_timeout, 1);
      check("to_complete", bus.complete, 1);
      finish_ack();
      // timeout disabled, then abort with idle_in
      bus.timeout_reg = '0;
      bus.strobe_in = 1;
      step();
      bus.strobe_in = 0;
      check("nt_flag_cleared", bus.data_timeout, 0);
      for (int i = 0; i < 70000; i++) step();
      check("nt_no_timeout", bus.data_timeout, 0);
      check("nt_still_read", bus.enable_stp_wrapper, 1);
      bus.idle_in = 1;
      step();
      bus.idle_in = 0;
      check("abort_idle", bus.serial_ready, 1);
      // DAT0 busy handling
      bus.write_read = 1;
      bus.timeout_reg = '0;
      bus.dat0_in = 0;
      bus.strobe_in = 1;
      step();
      bus.strobe_in = 0;
      write_block(3'b010);
`ifdef SD_DAT_BUSY_WAIT_EN
      for (int i = 0; i < 20; i++) step();
      check("busy_hold", {bus.pad_enable, bus.complete}, 2'b10);
      bus.dat0_in = 1;
      step();
      check("busy_exit", bus.complete, 1);
`else
      check("busy_ignored", bus.complete, 1);
`endif
      bus.dat0_in = 1;
      finish_ack();
      // asynchronous reset in SEND
      bus.strobe_in = 1;
      step();
      bus.strobe_in = 0;
      step();
      check("mid_send", bus.load_send, 1);
      reset = 0;
      #1;
      check("ar_load_send", bus.load_send, 0);
      check("ar_reset_wrapper", bus.reset_wrapper, 1);
      check("ar_pad", {bus.pad_enable, bus.pad_state}, 0);
      check("ar_blocks_done", bus.blocks_done, 0);
      step();
      reset = 1;
      step();
      check("ar_idle", bus.serial_ready, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
